addr_decode_reg: RTL and testbench

- Registered address decoder. Maps an input address onto an index by searching a runtime-supplied table of half-open address ranges (rules).
- Used by register banks (e.g. APB register files) and interconnect demuxes to select a target and flag unmapped accesses.
- Outputs are registered: one cycle of latency, one clock domain.

---
 rtl/addr_decode_reg_pkg.sv | 24 ++
 rtl/addr_rule_match.sv | 24 ++
 rtl/addr_decode_reg.sv | 117 +++++++++++
 tb/tb_addr_decode_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/addr_decode_reg_pkg.sv
// Shared types and constants for the registered address decoder.
// Provides a default 32-bit address and rule type. Instantiating modules may
// pass their own rule_t as long as it has idx, start_addr and end_addr fields.
package addr_decode_reg_pkg;

  localparam int unsigned AddrWidth32 = 32;

  typedef logic [AddrWidth32-1:0] addr32_t;

  // One half-open range [start_addr, end_addr) mapped onto idx.
  typedef struct packed {
    int unsigned idx;
    addr32_t     start_addr;
    addr32_t     end_addr;
  } rule32_t;

  localparam int unsigned RuleWidth32 = $bits(rule32_t);

  // Width of an index able to hold values 0 .. num_idx-1; never less than 1.
  function automatic int unsigned idx_width(int unsigned num_idx);
    return (num_idx > 1) ? $clog2(num_idx) : 1;
  endfunction

endpackage

// File: rtl/addr_rule_match.sv
// Combinational comparator for a single address rule.
// Ports:
//   addr_i       address under test
//   start_addr_i inclusive lower bound of the rule
//   end_addr_i   exclusive upper bound of the rule
//   match_o      high when start_addr_i <= addr_i < end_addr_i (unsigned)
// A rule with end_addr_i <= start_addr_i can never satisfy both bounds, so
// empty and inverted rules never match and no wrap-around is possible.
module addr_rule_match
  import addr_decode_reg_pkg::*;
#(
  parameter type addr_t = addr32_t
) (
  input  addr_t addr_i,
  input  addr_t start_addr_i,
  input  addr_t end_addr_i,
  output logic  match_o
);

  always_comb begin
    match_o = (addr_i >= start_addr_i) && (addr_i < end_addr_i);
  end

endmodule

// File: rtl/addr_decode_reg.sv
// Registered address decoder.
// Searches a runtime rule table for the range containing addr_i and reports
// the matching index one clock later. The highest-numbered matching rule wins.
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset, clears all outputs
//   addr_i           address to decode
//   addr_map_i       rule table, not stored; changes apply on the next edge
//   en_default_idx_i on a miss, report default_idx_i instead of an error
//   default_idx_i    index reported on a miss when the default is enabled
//   idx_o            registered decoded index
//   dec_valid_o      registered: some rule matched
//   dec_error_o      registered: no match and default disabled
module addr_decode_reg
  import addr_decode_reg_pkg::*;
#(
  parameter int unsigned NoIndices = 32'd1,
  parameter int unsigned NoRules   = 32'd1,
  parameter type         addr_t    = addr32_t,
  parameter type         rule_t    = rule32_t,
  parameter int unsigned IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  addr_t                 addr_i,
  input  rule_t [NoRules-1:0]   addr_map_i,
  input  logic                  en_default_idx_i,
  input  logic [IdxWidth-1:0]   default_idx_i,
  output logic [IdxWidth-1:0]   idx_o,
  output logic                  dec_valid_o,
  output logic                  dec_error_o
);

  logic [NoRules-1:0]  match;
  logic [IdxWidth-1:0] idx_d, idx_q;
  logic                valid_d, valid_q;
  logic                error_d, error_q;
  logic                unused_idx_bits;

  for (genvar r = 0; r < NoRules; r++) begin : g_rule
    addr_rule_match #(
      .addr_t (addr_t)
    ) u_match (
      .addr_i       (addr_i),
      .start_addr_i (addr_map_i[r].start_addr),
      .end_addr_i   (addr_map_i[r].end_addr),
      .match_o      (match[r])
    );
  end

  // Ascending scan: a later match overwrites an earlier one, so the highest
  // array position wins among overlapping rules.
  always_comb begin
    logic                hit;
    logic [IdxWidth-1:0] win_idx;
    hit             = 1'b0;
    win_idx         = '0;
    unused_idx_bits = 1'b0;
    for (int unsigned r = 0; r < NoRules; r++) begin
      unused_idx_bits = unused_idx_bits ^ (^addr_map_i[r].idx);
      if (match[r]) begin
        hit     = 1'b1;
        win_idx = IdxWidth'(addr_map_i[r].idx);
      end
    end

    idx_d   = '0;
    valid_d = 1'b0;
    error_d = 1'b0;
    if (hit) begin
      idx_d   = win_idx;
      valid_d = 1'b1;
    end else if (en_default_idx_i) begin
      idx_d = default_idx_i;
    end else begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign idx_o       = idx_q;
  assign dec_valid_o = valid_q;
  assign dec_error_o = error_q;

  initial begin : param_check
    if (NoIndices == 0) $fatal(1, "addr_decode_reg: NoIndices must be at least 1");
    if (NoRules == 0) $fatal(1, "addr_decode_reg: NoRules must be at least 1");
    if ($bits(addr_i) != $bits(addr_map_i[0].start_addr)) begin
      $fatal(1, "addr_decode_reg: addr_t width differs from rule start_addr width");
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned r = 0; r < NoRules; r++) begin
        assert (addr_map_i[r].idx < NoIndices)
          else $error("addr_decode_reg: rule %0d idx out of range", r);
      end
      if (en_default_idx_i) begin
        assert (default_idx_i < NoIndices)
          else $error("addr_decode_reg: default_idx_i out of range");
      end
    end
  end

endmodule

// File: tb/tb_addr_decode_reg.sv
// Self-checking bench for addr_decode_reg: table of directed vectors, random
// vectors against a reference search, and async reset sequences.
module tb_addr_decode_reg;
  import addr_decode_reg_pkg::*;

  localparam int unsigned NIdx   = 4;
  localparam int unsigned NRules = 4;
  localparam int unsigned IW     = 2;

  typedef rule32_t [NRules-1:0] map_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic          valid;
    logic          err;
    string         name;
  } exp_t;

  typedef struct {
    bit            sel_b;
    addr32_t       addr;
    logic          en;
    logic [IW-1:0] def;
    logic [IW-1:0] e_idx;
    logic          e_v;
    logic          e_e;
    string         name;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  addr32_t       addr;
  map_t          addr_map;
  logic          en_def;
  logic [IW-1:0] def_idx;
  logic [IW-1:0] idx;
  logic          valid;
  logic          err;

  exp_t sb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  map_t map_a;
  map_t map_b;

  always #5 clk = ~clk;

  addr_decode_reg #(
    .NoIndices (NIdx),
    .NoRules   (NRules),
    .addr_t    (addr32_t),
    .rule_t    (rule32_t)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .addr_i           (addr),
    .addr_map_i       (addr_map),
    .en_default_idx_i (en_def),
    .default_idx_i    (def_idx),
    .idx_o            (idx),
    .dec_valid_o      (valid),
    .dec_error_o      (err)
  );

  function automatic rule32_t mk_rule(int unsigned i, addr32_t s, addr32_t e);
    rule32_t rl;
    rl.idx        = i;
    rl.start_addr = s;
    rl.end_addr   = e;
    return rl;
  endfunction

  // Reference: scan from the top rule down, first hit wins.
  function automatic exp_t model(map_t m, addr32_t a, logic en, logic [IW-1:0] d);
    exp_t e;
    e.idx   = '0;
    e.valid = 1'b0;
    e.err   = !en;
    e.name  = "rand";
    if (en) e.idx = d;
    for (int r = NRules - 1; r >= 0; r--) begin
      if (m[r].start_addr <= a && a < m[r].end_addr) begin
        e.idx   = m[r].idx[IW-1:0];
        e.valid = 1'b1;
        e.err   = 1'b0;
        break;
      end
    end
    return e;
  endfunction

  task automatic check_now(exp_t e);
    total++;
    if (idx !== e.idx || valid !== e.valid || err !== e.err || (valid === 1'b1 && err === 1'b1)) begin
      bad++;
      $display("FAIL %s: got idx=%0d valid=%b err=%b, want idx=%0d valid=%b err=%b",
               e.name, idx, valid, err, e.idx, e.valid, e.err);
    end
  endtask

  // Drive one vector mid-cycle, push its expectation, compare after the edge.
  task automatic apply(map_t m, addr32_t a, logic en, logic [IW-1:0] d, exp_t e);
    exp_t got;
    @(negedge clk);
    addr_map = m;
    addr     = a;
    en_def   = en;
    def_idx  = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got no entry, want one");
    end else begin
      got = sb.pop_front();
      check_now(got);
    end
  endtask

  initial begin
    exp_t e;
    for (int r = 0; r < NRules; r++) begin
      map_a[r] = mk_rule(r, 32'h1000 + 4 * r, 32'h1004 + 4 * r);
    end
    map_b[0] = mk_rule(1, 32'h0000_0000, 32'h0000_0100);
    map_b[1] = mk_rule(2, 32'h0000_0080, 32'h0000_0090);
    map_b[2] = mk_rule(3, 32'h0000_0200, 32'h0000_0200);
    map_b[3] = mk_rule(3, 32'h0000_0280, 32'h0000_0220);

    vecs.push_back('{0, 32'h1008, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, "mid_rule"});
    vecs.push_back('{0, 32'h1010, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, "end_excl_err"});
    vecs.push_back('{0, 32'h1010, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, "end_excl_default"});
    vecs.push_back('{1, 32'h0084, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, "overlap_inner"});
    vecs.push_back('{1, 32'h007F, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, "overlap_below"});
    vecs.push_back('{1, 32'h0090, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, "overlap_above"});
    vecs.push_back('{0, 32'h1003, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, "last_byte_r0"});
    vecs.push_back('{0, 32'h1004, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, "first_byte_r1"});
    vecs.push_back('{1, 32'h0200, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, "empty_rule"});
    vecs.push_back('{1, 32'h0250, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, "inverted_rule"});
    vecs.push_back('{0, 32'h0FFF, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, "below_map"});
    vecs.push_back('{0, 32'h1000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, "b2b_0"});
    vecs.push_back('{0, 32'h100C, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, "b2b_1"});
    vecs.push_back('{0, 32'h2000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, "b2b_2"});

    // Reset holds outputs at zero even with a matching input.
    rst      = 1'b1;
    addr_map = map_a;
    addr     = 32'h1008;
    en_def   = 1'b0;
    def_idx  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_now('{2'd0, 1'b0, 1'b0, "reset_state"});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_now('{2'd2, 1'b1, 1'b0, "first_after_reset"});

    foreach (vecs[i]) begin
      e.idx   = vecs[i].e_idx;
      e.valid = vecs[i].e_v;
      e.err   = vecs[i].e_e;
      e.name  = vecs[i].name;
      apply(vecs[i].sel_b ? map_b : map_a, vecs[i].addr, vecs[i].en, vecs[i].def, e);
    end

    for (int i = 0; i < 40; i++) begin
      addr32_t       a;
      logic          en;
      logic [IW-1:0] d;
      bit            use_b;
      use_b = (i % 2) == 1;
      a     = use_b ? addr32_t'($urandom_range(0, 32'h3FF))
                    : addr32_t'(32'h0FF8 + $urandom_range(0, 31));
      en    = 1'($urandom_range(0, 1));
      d     = IW'($urandom_range(0, NIdx - 1));
      apply(use_b ? map_b : map_a, a, en, d, model(use_b ? map_b : map_a, a, en, d));
    end

    // Async reset mid-cycle while a valid result is held.
    apply(map_a, 32'h100C, 1'b0, 2'd0, '{2'd3, 1'b1, 1'b0, "pre_async_rst"});
    #2;
    rst = 1'b1;
    #1;
    check_now('{2'd0, 1'b0, 1'b0, "async_rst_immediate"});
    @(posedge clk);
    #1;
    check_now('{2'd0, 1'b0, 1'b0, "rst_hold_edge"});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_now('{2'd0, 1'b0, 1'b0, "rst_release_no_edge"});
    @(posedge clk);
    #1;
    check_now('{2'd3, 1'b1, 1'b0, "first_edge_after_rst"});

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end

endmodule
